// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall handshake bundle between the pipeline datapath and the stall controller.
// The master side (datapath) drives the ID/EX hazard inputs; the slave side (controller) drives the enables.
interface hazard_stall_controller_if;
  logic [3:0] id_op1;
  logic [3:0] id_op2;
  logic       id_uses_op2;
  logic [3:0] ex_opcode;
  logic [3:0] ex_dest;
  logic       ex_md_start;
  logic       ex_branch_tkn;
  logic       halt_req;
  logic       resume;

  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_flush;
  logic       exmem_bubble;
  logic       halted;

  modport master (
    output id_op1, id_op2, id_uses_op2, ex_opcode, ex_dest,
           ex_md_start, ex_branch_tkn, halt_req, resume,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_bubble, halted
  );

  modport slave (
    input  id_op1, id_op2, id_uses_op2, ex_opcode, ex_dest,
           ex_md_start, ex_branch_tkn, halt_req, resume,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_bubble, halted
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use bubbles, taken-branch flushes, mul/div freeze and HALT parking.
// Optional STALL_PERF_EN macro builds a saturating front-end stall-cycle counter.
module hazard_stall_controller #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 3,
  parameter int PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_stall_controller_if.slave hz,
  input  logic                  perf_clr,
  output logic [PERF_W-1:0]     stall_cycles
);

  typedef enum logic [1:0] {RUN, MD_WAIT, HALT} state_t;

  localparam bit              MD_EN    = (MD_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MD_LATENCY > 1) ? (MD_LATENCY - 2) : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             halt_pend;

  logic is_load;
  logic load_use;
  logic md_go;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_flush;
  logic exmem_bubble;
  logic halted;

  assign is_load  = (hz.ex_opcode == 4'b0100) || (hz.ex_opcode == 4'b0110);
  assign load_use = is_load &&
                    ((hz.ex_dest == hz.id_op1) ||
                     (hz.id_uses_op2 && (hz.ex_dest == hz.id_op2)));
  assign md_go    = hz.ex_md_start && MD_EN;

  // Sequencer state: the mul/div countdown and a deferred HALT captured while frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      halt_pend <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (md_go) begin
            state <= MD_WAIT;
            cnt   <= CNT_LOAD;
          end else if (!hz.ex_branch_tkn && !load_use && hz.halt_req) begin
            state <= HALT;
          end
        end
        MD_WAIT: begin
          if (cnt == '0) begin
            state     <= (halt_pend || hz.halt_req) ? HALT : RUN;
            halt_pend <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (hz.halt_req) halt_pend <= 1'b1;
          end
        end
        HALT: begin
          if (hz.resume) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Enables act in the same cycle; everything is forced low while reset is held
  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_write   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    halted       = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          idex_write = 1'b1;
          if (md_go) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
          end else if (hz.ex_branch_tkn) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use || hz.halt_req) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          exmem_bubble = 1'b1;
        end
        HALT: begin
          idex_write = 1'b1;
          idex_flush = 1'b1;
          halted     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_write   = idex_write;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_bubble = exmem_bubble;
  assign hz.halted       = halted;

`ifdef STALL_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  // Stall counter: clear beats increment, holds at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (!pc_write) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end
`else
  logic perf_clr_unused;
  assign perf_clr_unused = perf_clr;
  assign stall_cycles    = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: MD_LATENCY=4 main instance plus an MD_LATENCY=1, PERF_W=2 instance.
module tb_hazard_stall_controller;

  logic clk;
  logic rst_n;
  logic perf_clr;
  logic [15:0] stall_a;
  logic [1:0]  stall_b;

  int total;
  int bad;

  hazard_stall_controller_if a ();
  hazard_stall_controller_if b ();

  hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(3), .PERF_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .hz(a), .perf_clr(perf_clr), .stall_cycles(stall_a)
  );

  hazard_stall_controller #(.MD_LATENCY(1), .CNT_W(3), .PERF_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .hz(b), .perf_clr(perf_clr), .stall_cycles(stall_b)
  );

  assign b.id_op1        = a.id_op1;
  assign b.id_op2        = a.id_op2;
  assign b.id_uses_op2   = a.id_uses_op2;
  assign b.ex_opcode     = a.ex_opcode;
  assign b.ex_dest       = a.ex_dest;
  assign b.ex_md_start   = a.ex_md_start;
  assign b.ex_branch_tkn = a.ex_branch_tkn;
  assign b.halt_req      = a.halt_req;
  assign b.resume        = a.resume;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, halted}
  logic [6:0] oa, ob;
  assign oa = {a.pc_write, a.ifid_write, a.ifid_flush, a.idex_write, a.idex_flush, a.exmem_bubble, a.halted};
  assign ob = {b.pc_write, b.ifid_write, b.ifid_flush, b.idex_write, b.idex_flush, b.exmem_bubble, b.halted};

  localparam logic [6:0] O_RST = 7'b0000000;
  localparam logic [6:0] O_DEF = 7'b1101000;
  localparam logic [6:0] O_LU  = 7'b0001100;
  localparam logic [6:0] O_BR  = 7'b1111100;
  localparam logic [6:0] O_MD  = 7'b0000010;
  localparam logic [6:0] O_HLT = 7'b0001101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge
  task automatic step(input string tag, input logic [6:0] exp);
    @(negedge clk);
    chk(tag, {25'd0, oa}, {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a.ex_opcode     = 4'b0000;
    a.ex_dest       = 4'd15;
    a.id_op1        = 4'd1;
    a.id_op2        = 4'd2;
    a.id_uses_op2   = 1'b0;
    a.ex_md_start   = 1'b0;
    a.ex_branch_tkn = 1'b0;
    a.halt_req      = 1'b0;
    a.resume        = 1'b0;
  endtask

  task automatic set_lu(input logic [3:0] op, input logic [3:0] dst,
                        input logic [3:0] r1, input logic [3:0] r2, input logic use2);
    a.ex_opcode   = op;
    a.ex_dest     = dst;
    a.id_op1      = r1;
    a.id_op2      = r2;
    a.id_uses_op2 = use2;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    perf_clr = 1'b0;
    rst_n    = 1'b0;
    idle();

    step("reset_outs", O_RST);
    chk("reset_stall", {16'd0, stall_a}, 32'd0);
    rst_n = 1'b1;
    step("idle", O_DEF);

    set_lu(4'b0110, 4'd3, 4'd3, 4'd0, 1'b0);
    step("lu_op1", O_LU);
    idle();
    step("lu_after", O_DEF);
    set_lu(4'b0110, 4'd3, 4'd1, 4'd3, 1'b0);
    step("lu_op2_unused", O_DEF);
    set_lu(4'b0110, 4'd3, 4'd1, 4'd3, 1'b1);
    step("lu_op2_used", O_LU);
    set_lu(4'b0100, 4'd5, 4'd5, 4'd2, 1'b0);
    step("lu_op0100", O_LU);
    set_lu(4'b0101, 4'd5, 4'd5, 4'd2, 1'b0);
    step("not_load", O_DEF);

    set_lu(4'b0110, 4'd3, 4'd3, 4'd0, 1'b0);
    a.ex_branch_tkn = 1'b1;
    step("branch_over_lu", O_BR);
    idle();
    step("branch_after", O_DEF);

    a.ex_md_start = 1'b1;
    #1 chk("md_lat1_nostall", {25'd0, ob}, {25'd0, O_DEF});
    step("md0", O_MD);
    step("md1_restart_ignored", O_MD);
    a.ex_md_start   = 1'b0;
    a.ex_branch_tkn = 1'b1;
    step("md2_branch_ignored", O_MD);
    a.ex_branch_tkn = 1'b0;
    step("md3", O_MD);
    step("md_done", O_DEF);

    a.ex_md_start = 1'b1;
    step("mdh0", O_MD);
    a.ex_md_start = 1'b0;
    a.halt_req    = 1'b1;
    step("mdh1", O_MD);
    a.halt_req    = 1'b0;
    step("mdh2", O_MD);
    step("mdh3", O_MD);
    step("mdh_halt", O_HLT);
    step("mdh_halt_hold", O_HLT);
    a.resume = 1'b1;
    step("mdh_resume_cyc", O_HLT);
    a.resume = 1'b0;
    step("mdh_run", O_DEF);

    a.resume = 1'b1;
    step("resume_in_run", O_DEF);
    a.resume = 1'b0;
    a.halt_req = 1'b1;
    step("halt_req_run", O_LU);
    a.halt_req = 1'b0;
    step("halt_state", O_HLT);
    a.resume = 1'b1;
    step("halt_resume", O_HLT);
    a.resume = 1'b0;
    step("halt_left", O_DEF);

    a.ex_md_start = 1'b1;
    step("mdr0", O_MD);
    a.ex_md_start = 1'b0;
    step("mdr1", O_MD);
    rst_n = 1'b0;
    #1 chk("rst_async_outs", {25'd0, oa}, {25'd0, O_RST});
    step("rst_mid_md", O_RST);
    rst_n = 1'b1;
    step("rst_release", O_DEF);
    a.ex_md_start = 1'b1;
    step("mdc0", O_MD);
    a.ex_md_start = 1'b0;
    step("mdc1", O_MD);
    step("mdc2", O_MD);
    step("mdc3", O_MD);
    step("mdc_done", O_DEF);

`ifdef STALL_PERF_EN
    perf_clr = 1'b1;
    step("perf_clr_cyc", O_DEF);
    perf_clr = 1'b0;
    chk("perf_cleared_a", {16'd0, stall_a}, 32'd0);
    chk("perf_cleared_b", {30'd0, stall_b}, 32'd0);
    set_lu(4'b0110, 4'd3, 4'd3, 4'd0, 1'b0);
    step("perf_lu1", O_LU);
    step("perf_lu2", O_LU);
    step("perf_lu3", O_LU);
    idle();
    chk("perf_three_a", {16'd0, stall_a}, 32'd3);
    chk("perf_three_b", {30'd0, stall_b}, 32'd3);
    set_lu(4'b0110, 4'd3, 4'd3, 4'd0, 1'b0);
    step("perf_lu4", O_LU);
    step("perf_lu5", O_LU);
    idle();
    chk("perf_five_a", {16'd0, stall_a}, 32'd5);
    chk("perf_sat_b", {30'd0, stall_b}, 32'd3);
`else
    chk("perf_off_a", {16'd0, stall_a}, 32'd0);
    chk("perf_off_b", {30'd0, stall_b}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
